priority_code_capture: RTL and testbench

- Downstream consumer of the 8-to-3 priority encoder on the lab board.
- Synchronises and debounces the encoder's active-low code and group lines, then captures one code per distinct press.
- Buffers captured codes in a small FIFO with a valid/ready handshake, so later stages (display driver, counters) can read each press exactly once.

---
 rtl/priority_capture_pkg.sv | 20 ++
 rtl/priority_code_capture_fifo.sv | 66 ++++++
 rtl/priority_code_capture.sv | 166 ++++++++++++++++
 tb/tb_priority_code_capture.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/priority_capture_pkg.sv
// Shared definitions for the priority-encoder code capture block.
//   captureStateT : capture FSM states
//   CODE_W        : width of the encoder code
//   countWidth()  : width needed to hold a FIFO fill level of 0..depth
package priority_capture_pkg;

  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } captureStateT;

  function automatic int countWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/priority_code_capture_fifo.sv
// code_fifo: small synchronous FIFO with first-word fall-through head.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   push, pushData    : write request and data (ignored when full unless popping)
//   pop               : read request (ignored when empty)
//   head              : entry at the read pointer, valid whenever !empty
//   count             : number of stored entries
//   full, empty       : fill-level flags
module code_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 3
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            push,
  input  logic [WIDTH-1:0]                pushData,
  input  logic                            pop,
  output logic [WIDTH-1:0]                head,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count,
  output logic                            full,
  output logic                            empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rdPtr];

  // A pop frees a slot on the same edge, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; entries are only observable
  // through the pointers and count, which are reset, so clearing the array
  // would add a reset net to every bit for no functional gain.
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/priority_code_capture.sv
// priority_code_capture: synchronises and debounces the active-low outputs of
// the lab-board 8-to-3 priority encoder, captures one true-polarity code per
// distinct press and buffers it in a valid/ready FIFO.
// Ports:
//   clock, reset   : rising-edge clock, synchronous active-high reset
//   codeN, groupN  : asynchronous encoder code / group request, active-low
//   codeOut        : head-of-FIFO code (true polarity), 0 when codeValid=0
//   codeValid      : FIFO not empty
//   codeReady      : consumer takes the head when codeValid&codeReady
//   fifoCount      : number of stored codes
//   overflow       : sticky, a capture was dropped on a full FIFO
//   clearOverflow  : clears overflow on the next edge (a new drop wins)
//   busy           : capture FSM is not in IDLE
// Build option:
//   CAPTURE_REPEAT_EN : re-push the held code every REPEAT_CYCLES while the
//                       press stays stable in HOLD (auto-repeat).
module priority_code_capture
  import priority_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [CODE_W-1:0]                    codeN,
  input  logic                                 groupN,
  output logic [CODE_W-1:0]                    codeOut,
  output logic                                 codeValid,
  input  logic                                 codeReady,
  output logic [countWidth(FIFO_DEPTH)-1:0]    fifoCount,
  output logic                                 overflow,
  input  logic                                 clearOverflow,
  output logic                                 busy
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  if (DEBOUNCE_CYCLES < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
      || REPEAT_CYCLES < 1) begin : gBadParams
    $error("priority_code_capture: illegal parameter combination");
  end

  // Sample layout is {group, code}; both flops reset to all-ones (inactive).
  logic [CODE_W:0]   syncA;
  logic [CODE_W:0]   syncB;
  logic [DB_W-1:0]   stableCnt;
  logic              stable;
  logic              sampleChanging;
  logic              groupS;
  logic [CODE_W-1:0] codeTrue;
  logic [CODE_W-1:0] heldCode;

  captureStateT      state;
  captureStateT      nextState;
  logic              capturePush;
  logic              repeatPush;
  logic              push;

  logic [CODE_W-1:0] fifoHead;
  logic              fifoFull;
  logic              fifoEmpty;
  logic              popFire;

  assign groupS   = syncB[CODE_W];
  assign codeTrue = ~syncB[CODE_W-1:0];
  assign stable   = (stableCnt == DB_W'(DEBOUNCE_CYCLES));

  // syncA holds the value S takes on the next edge, so comparing the two
  // stages tells us S is about to change; the counter therefore reads 0 in
  // exactly the cycle in which S differs from its previous value.
  assign sampleChanging = (syncA != syncB);

  // NOTE: every register here uses non-blocking assignment so syncB samples
  // the pre-edge value of syncA; a blocking assignment would collapse the
  // two synchroniser stages into one.
  always_ff @(posedge clock) begin
    if (reset) begin
      syncA     <= '1;
      syncB     <= '1;
      stableCnt <= '0;
      state     <= IDLE;
      heldCode  <= '0;
      overflow  <= 1'b0;
    end else begin
      syncA <= {groupN, codeN};
      syncB <= syncA;
      if (sampleChanging)  stableCnt <= '0;
      else if (!stable)    stableCnt <= stableCnt + 1'b1;
      state <= nextState;
      if (capturePush) heldCode <= codeTrue;
      // A drop on this edge takes priority over a clear request.
      if (push && fifoFull && !popFire) overflow <= 1'b1;
      else if (clearOverflow)           overflow <= 1'b0;
    end
  end

  // NOTE: defaults are assigned before the case so that every path drives
  // every output; otherwise always_comb would infer latches.
  always_comb begin
    nextState   = state;
    capturePush = 1'b0;
    case (state)
      IDLE: begin
        if (!groupS) nextState = SETTLE;
      end
      SETTLE: begin
        if (groupS) begin
          nextState = IDLE;
        end else if (stable) begin
          capturePush = 1'b1;
          nextState   = HOLD;
        end
      end
      HOLD: begin
        if (groupS)                    nextState = RELEASE;
        else if (codeTrue != heldCode) nextState = SETTLE;  // higher-priority key
      end
      RELEASE: begin
        if (!groupS)     nextState = SETTLE;
        else if (stable) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

`ifdef CAPTURE_REPEAT_EN
  localparam int RP_W = $clog2(REPEAT_CYCLES + 1);

  logic [RP_W-1:0] repeatCnt;

  assign repeatPush = (state == HOLD) && !groupS && (codeTrue == heldCode)
                      && (repeatCnt == RP_W'(REPEAT_CYCLES));

  // Cleared while outside HOLD (covers entry to HOLD) and whenever S moves.
  always_ff @(posedge clock) begin
    if (reset || state != HOLD || sampleChanging || repeatPush) repeatCnt <= '0;
    else                                                         repeatCnt <= repeatCnt + 1'b1;
  end
`else
  assign repeatPush = 1'b0;
`endif

  assign push    = capturePush || repeatPush;
  assign popFire = codeValid && codeReady;

  code_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (CODE_W)
  ) uFifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .pushData (codeTrue),
    .pop      (codeReady),
    .head     (fifoHead),
    .count    (fifoCount),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  assign codeValid = !fifoEmpty;
  assign codeOut   = fifoEmpty ? '0 : fifoHead;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_priority_code_capture.sv
// Directed self-checking bench for priority_code_capture with
// DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, REPEAT_CYCLES=16. Inputs are driven 1 time
// unit after a rising edge and outputs are sampled at the same point, so an
// input applied now is first sampled by the next edge (edge k); the push lands
// on edge k+6, i.e. the 7th tick after the input is applied.
module tb_priority_code_capture;

  localparam int CNT_W = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic [2:0]       codeN;
  logic             groupN;
  logic [2:0]       codeOut;
  logic             codeValid;
  logic             codeReady;
  logic [CNT_W-1:0] fifoCount;
  logic             overflow;
  logic             clearOverflow;
  logic             busy;

  int vectors     = 0;
  int miscompares = 0;
  int pushes;

  priority_code_capture #(
    .DEBOUNCE_CYCLES (4),
    .FIFO_DEPTH      (4),
    .REPEAT_CYCLES   (16)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .codeN         (codeN),
    .groupN        (groupN),
    .codeOut       (codeOut),
    .codeValid     (codeValid),
    .codeReady     (codeReady),
    .fifoCount     (fifoCount),
    .overflow      (overflow),
    .clearOverflow (clearOverflow),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pressKey(input logic [2:0] code);
    groupN = 1'b0;
    codeN  = code;
  endtask

  task automatic releaseKey();
    groupN = 1'b1;
    codeN  = 3'b111;
  endtask

  task automatic popOne();
    codeReady = 1'b1;
    tick();
    codeReady = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    groupN        = 1'b1;
    codeN         = 3'b111;
    codeReady     = 1'b0;
    clearOverflow = 1'b0;
    tick(2);
    check("rst_valid", codeValid, 0);
    check("rst_code",  codeOut,   0);
    check("rst_count", fifoCount, 0);
    check("rst_ovf",   overflow,  0);
    check("rst_busy",  busy,      0);
    reset = 1'b0;
    tick(3);

    // Clean press of code 010 -> true 101
    pressKey(3'b010);
    tick(6);
    check("clean_early_valid", codeValid, 0);
    check("clean_early_busy",  busy,      1);
    tick(1);
    check("clean_valid", codeValid, 1);
    check("clean_code",  codeOut,   3'b101);
    check("clean_count", fifoCount, 1);
    tick(13);
    releaseKey();
    tick(10);
    check("clean_single_push", fifoCount, 1);
    check("clean_idle",        busy,      0);
    popOne();
    check("clean_pop_valid", codeValid, 0);
    check("clean_pop_code",  codeOut,   0);

    // Bouncing group line, then a stable press of 000 -> true 111
    codeN = 3'b000;
    for (int i = 0; i < 6; i++) begin
      groupN = i[0];
      tick(2);
      check("bounce_no_capture", fifoCount, 0);
    end
    groupN = 1'b0;
    tick(6);
    check("bounce_early_valid", codeValid, 0);
    tick(1);
    check("bounce_valid", codeValid, 1);
    check("bounce_code",  codeOut,   3'b111);
    releaseKey();
    tick(10);
    check("bounce_count", fifoCount, 1);
    popOne();

    // Priority change while held: 110 (true 001) then 000 (true 111)
    pressKey(3'b110);
    tick(7);
    check("prio_first_count", fifoCount, 1);
    tick(5);
    codeN = 3'b000;
    tick(6);
    check("prio_second_early", fifoCount, 1);
    tick(1);
    check("prio_second_count", fifoCount, 2);
    check("prio_head_first",   codeOut,   3'b001);
    popOne();
    check("prio_head_second",  codeOut,   3'b111);
    popOne();
    check("prio_drained", codeValid, 0);
    releaseKey();
    tick(10);

    // Overflow: five presses with no consumer (true codes 1..5)
    pressKey(3'b110); tick(10); releaseKey(); tick(10);
    pressKey(3'b101); tick(10); releaseKey(); tick(10);
    pressKey(3'b100); tick(10); releaseKey(); tick(10);
    pressKey(3'b011); tick(10); releaseKey(); tick(10);
    check("ovf_not_yet", overflow, 0);
    pressKey(3'b010); tick(10); releaseKey(); tick(10);
    check("ovf_count", fifoCount, 4);
    check("ovf_flag",  overflow,  1);
    check("ovf_head",  codeOut,   3'b001);
    clearOverflow = 1'b1;
    tick();
    clearOverflow = 1'b0;
    check("ovf_cleared", overflow, 0);
    // Push of true 110 coinciding with a pop while full
    pressKey(3'b001);
    tick(6);
    codeReady = 1'b1;
    tick(1);
    codeReady = 1'b0;
    check("full_pushpop_count", fifoCount, 4);
    check("full_pushpop_ovf",   overflow,  0);
    check("full_pushpop_head",  codeOut,   3'b010);
    releaseKey();
    tick(10);
    popOne(); popOne(); popOne();
    check("full_pushpop_tail", codeOut, 3'b110);
    popOne();
    check("ovf_drained", codeValid, 0);
    codeReady = 1'b1;
    tick(2);
    codeReady = 1'b0;
    check("pop_empty_ignored", fifoCount, 0);

    // Reset during HOLD with two codes stored
    pressKey(3'b110); tick(10); releaseKey(); tick(10);
    pressKey(3'b101); tick(10);
    check("rmid_count_before", fifoCount, 2);
    check("rmid_busy_before",  busy,      1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rmid_valid", codeValid, 0);
    check("rmid_count", fifoCount, 0);
    check("rmid_busy",  busy,      0);
    tick(6);
    check("rmid_early_valid", codeValid, 0);
    tick(1);
    check("rmid_recapture_valid", codeValid, 1);
    check("rmid_recapture_code",  codeOut,   3'b010);
    releaseKey();
    tick(10);
    popOne();

    // Long hold with consumer ready: auto-repeat only when built with it
    codeReady = 1'b1;
    pushes    = 0;
    pressKey(3'b011);
    repeat (66) begin
      tick();
      if (codeValid) begin
        pushes++;
        check("repeat_code", codeOut, 3'b100);
      end
    end
    releaseKey();
    repeat (10) begin
      tick();
      if (codeValid) pushes++;
    end
    codeReady = 1'b0;
`ifdef CAPTURE_REPEAT_EN
    check("repeat_push_total", 8'(pushes), 4);
`else
    check("repeat_push_total", 8'(pushes), 1);
`endif
    check("repeat_final_empty", fifoCount, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
